// File: rtl/qgh_glyph_loader_if.sv
// qgh_glyph_loader_if: byte-stream input and glyph output bundle for the glyph loader
interface qgh_glyph_loader_if #(
  parameter int GLYPH_SIZE = 64,
  parameter int CNT_W      = 16
);
  logic                    s_valid;
  logic                    s_ready;
  logic [7:0]              s_data;
  logic                    s_last;
  logic                    flush;
  logic [8*GLYPH_SIZE-1:0] glyph_out;
  logic                    glyph_valid;
  logic                    err_short;
  logic                    err_long;
  logic [CNT_W-1:0]        glyph_count;
  modport master (
    output s_valid, s_data, s_last, flush,
    input  s_ready, glyph_out, glyph_valid, err_short, err_long, glyph_count
  );
  modport slave (
    input  s_valid, s_data, s_last, flush,
    output s_ready, glyph_out, glyph_valid, err_short, err_long, glyph_count
  );
endinterface

// File: rtl/qgh_glyph_loader.sv
// qgh_glyph_loader: assembles last-marked byte frames into glyphs, rate-limits glyph_valid pulses
module qgh_glyph_loader #(
  parameter int GLYPH_SIZE = 64,
  parameter int MIN_GAP    = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  qgh_glyph_loader_if.slave bus
);
  localparam int IW = $clog2(GLYPH_SIZE);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int GB = 8 * GLYPH_SIZE;
  typedef enum logic [1:0] {FILL, DISCARD, WAIT} state_t;
  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [GW-1:0] gap_cnt;
  logic [GB-1:0] fill_buf, buf_n;
  logic          accept, last_idx, commit, short_n, long_n;
  assign accept   = bus.s_valid && bus.s_ready;
  assign last_idx = idx == IW'(GLYPH_SIZE - 1);
  // buf_n includes the byte accepted this cycle so a commit on the final byte sees it
  always_comb begin
    state_n = state;
    idx_n   = idx;
    buf_n   = fill_buf;
    commit  = 1'b0;
    short_n = 1'b0;
    long_n  = 1'b0;
    case (state)
      FILL: if (accept) begin
        buf_n[8*idx +: 8] = bus.s_data;
        if (bus.s_last && last_idx) begin
          idx_n   = '0;
          commit  = gap_cnt == '0;
          state_n = gap_cnt == '0 ? FILL : WAIT;
        end else if (bus.s_last) begin
          short_n = 1'b1;
          idx_n   = '0;
        end else if (last_idx) begin
          long_n  = 1'b1;
          idx_n   = '0;
          state_n = DISCARD;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      DISCARD: if (accept && bus.s_last) begin
        state_n = FILL;
        idx_n   = '0;
      end
      WAIT: if (gap_cnt == '0) begin
        commit  = 1'b1;
        state_n = FILL;
        idx_n   = '0;
      end
      default: state_n = FILL;
    endcase
    if (bus.flush) begin
      state_n = FILL;
      idx_n   = '0;
      commit  = 1'b0;
      short_n = 1'b0;
      long_n  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= FILL;
      idx             <= '0;
      gap_cnt         <= '0;
      fill_buf        <= '0;
      bus.s_ready     <= 1'b0;
      bus.glyph_out   <= '0;
      bus.glyph_valid <= 1'b0;
      bus.err_short   <= 1'b0;
      bus.err_long    <= 1'b0;
      bus.glyph_count <= '0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      gap_cnt         <= commit ? GW'(MIN_GAP - 1) : (gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt);
      fill_buf        <= buf_n;
      bus.s_ready     <= state_n != WAIT;
      bus.glyph_out   <= commit ? buf_n : bus.glyph_out;
      bus.glyph_valid <= commit;
      bus.err_short   <= short_n;
      bus.err_long    <= long_n;
      bus.glyph_count <= bus.glyph_count + CNT_W'(commit);
    end
  end
endmodule

// File: tb/tb_qgh_glyph_loader.sv
// tb_qgh_glyph_loader: directed checks of framing, errors, spacing, flush, reset and count wrap
module tb_qgh_glyph_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc1;
  logic seen;
  qgh_glyph_loader_if #(.GLYPH_SIZE(4), .CNT_W(16)) b ();
  qgh_glyph_loader_if #(.GLYPH_SIZE(4), .CNT_W(2))  b2 ();
  assign b2.s_valid = b.s_valid;
  assign b2.s_data  = b.s_data;
  assign b2.s_last  = b.s_last;
  assign b2.flush   = b.flush;
  qgh_glyph_loader #(.GLYPH_SIZE(4), .MIN_GAP(8), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  qgh_glyph_loader #(.GLYPH_SIZE(4), .MIN_GAP(8), .CNT_W(2))  dut_w (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    b.s_valid = 1'b1;
    b.s_data  = d;
    b.s_last  = l;
    while (b.s_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("send_ready_timeout", 64'(b.s_ready), 64'd1);
    step();
    b.s_valid = 1'b0;
    b.s_last  = 1'b0;
  endtask
  task automatic wait_glyph();
    int n;
    n = 0;
    while (b.glyph_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask
  task automatic frame4(input logic [7:0] d0, d1, d2, d3);
    send(d0, 1'b0);
    send(d1, 1'b0);
    send(d2, 1'b0);
    send(d3, 1'b1);
  endtask
  initial begin
    b.s_valid = 1'b0;
    b.s_data  = 8'h00;
    b.s_last  = 1'b0;
    b.flush   = 1'b0;
    step();
    step();
    chk("rst_ready", 64'(b.s_ready), 64'd0);
    chk("rst_glyph_out", 64'(b.glyph_out), 64'd0);
    chk("rst_valid", 64'(b.glyph_valid), 64'd0);
    chk("rst_count", 64'(b.glyph_count), 64'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(b.s_ready), 64'd0);
    step();
    chk("ready_after_release", 64'(b.s_ready), 64'd1);
    frame4(8'h11, 8'h22, 8'h33, 8'h44);
    chk("g1_valid_latency", 64'(b.glyph_valid), 64'd1);
    chk("g1_out", 64'(b.glyph_out), 64'h44332211);
    chk("g1_count", 64'(b.glyph_count), 64'd1);
    cyc1 = cyc;
    frame4(8'h55, 8'h66, 8'h77, 8'h88);
    chk("g2_wait_ready_low", 64'(b.s_ready), 64'd0);
    chk("g2_not_yet", 64'(b.glyph_valid), 64'd0);
    wait_glyph();
    chk("g2_valid", 64'(b.glyph_valid), 64'd1);
    chk("g2_spacing", 64'(cyc - cyc1), 64'd8);
    chk("g2_out", 64'(b.glyph_out), 64'h88776655);
    chk("g2_count", 64'(b.glyph_count), 64'd2);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk("short_err", 64'(b.err_short), 64'd1);
    chk("short_no_long", 64'(b.err_long), 64'd0);
    chk("short_no_valid", 64'(b.glyph_valid), 64'd0);
    chk("short_out_kept", 64'(b.glyph_out), 64'h88776655);
    step();
    chk("short_pulse_width", 64'(b.err_short), 64'd0);
    frame4(8'h01, 8'h02, 8'h03, 8'h04);
    wait_glyph();
    chk("g3_valid", 64'(b.glyph_valid), 64'd1);
    chk("g3_out", 64'(b.glyph_out), 64'h04030201);
    chk("g3_count", 64'(b.glyph_count), 64'd3);
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    chk("long_not_early", 64'(b.err_long), 64'd0);
    send(8'h13, 1'b0);
    chk("long_err", 64'(b.err_long), 64'd1);
    chk("long_no_short", 64'(b.err_short), 64'd0);
    send(8'h14, 1'b0);
    chk("long_pulse_width", 64'(b.err_long), 64'd0);
    send(8'h15, 1'b1);
    chk("long_drop_no_valid", 64'(b.glyph_valid), 64'd0);
    chk("long_drop_no_err", 64'(b.err_long | b.err_short), 64'd0);
    chk("long_count_kept", 64'(b.glyph_count), 64'd3);
    frame4(8'h21, 8'h22, 8'h23, 8'h24);
    wait_glyph();
    chk("g4_out", 64'(b.glyph_out), 64'h24232221);
    chk("g4_count", 64'(b.glyph_count), 64'd4);
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    b.flush = 1'b1;
    step();
    b.flush = 1'b0;
    chk("flush_no_pulse", 64'(b.glyph_valid | b.err_short | b.err_long), 64'd0);
    frame4(8'h41, 8'h42, 8'h43, 8'h44);
    wait_glyph();
    chk("flush_new_frame", 64'(b.glyph_out), 64'h44434241);
    chk("flush_count", 64'(b.glyph_count), 64'd5);
    frame4(8'h51, 8'h52, 8'h53, 8'h54);
    chk("wflush_in_wait", 64'(b.s_ready), 64'd0);
    b.flush = 1'b1;
    step();
    b.flush = 1'b0;
    chk("wflush_ready_back", 64'(b.s_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= b.glyph_valid;
    end
    chk("wflush_never_emitted", 64'(seen), 64'd0);
    chk("wflush_out_kept", 64'(b.glyph_out), 64'h44434241);
    chk("wflush_count_kept", 64'(b.glyph_count), 64'd5);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    b.flush = 1'b1;
    send(8'h64, 1'b1);
    b.flush = 1'b0;
    chk("lflush_no_valid", 64'(b.glyph_valid), 64'd0);
    chk("lflush_count", 64'(b.glyph_count), 64'd5);
    send(8'h71, 1'b0);
    send(8'h72, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mrst_ready", 64'(b.s_ready), 64'd0);
    chk("mrst_out", 64'(b.glyph_out), 64'd0);
    chk("mrst_count", 64'(b.glyph_count), 64'd0);
    chk("mrst_pulses", 64'(b.glyph_valid | b.err_short | b.err_long), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_ready_after", 64'(b.s_ready), 64'd1);
    frame4(8'h81, 8'h82, 8'h83, 8'h84);
    chk("g5_valid_latency", 64'(b.glyph_valid), 64'd1);
    chk("g5_out", 64'(b.glyph_out), 64'h84838281);
    chk("g5_count", 64'(b.glyph_count), 64'd1);
    step();
    chk("g5_pulse_width", 64'(b.glyph_valid), 64'd0);
    chk("g5_out_stable", 64'(b.glyph_out), 64'h84838281);
    frame4(8'h91, 8'h92, 8'h93, 8'h94);
    chk("wrst_in_wait", 64'(b.s_ready), 64'd0);
    rst_n = 1'b0;
    #2;
    chk("wrst_out", 64'(b.glyph_out), 64'd0);
    chk("wrst_count", 64'(b.glyph_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("wrst_no_pulse", 64'(b.glyph_valid), 64'd0);
    for (int g = 0; g < 5; g++) begin
      frame4({4'(g), 4'd1}, {4'(g), 4'd2}, {4'(g), 4'd3}, {4'(g), 4'd4});
      wait_glyph();
      chk("wrap_glyph_valid", 64'(b.glyph_valid), 64'd1);
    end
    chk("wrap_main_count", 64'(b.glyph_count), 64'd5);
    chk("wrap_small_count", 64'(b2.glyph_count), 64'd1);
    chk("wrap_small_out", 64'(b2.glyph_out), 64'h44434241);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
